// File: rtl/ir_pkg.sv
// Shared definitions for the IR remote path: frame field layout and key-filter FSM states.
package ir_pkg;

    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 7;
    localparam int CMD_MSB  = 6;
    localparam int CMD_LSB  = 0;
    localparam int FRAME_W  = ADDR_MSB + 1;

    typedef struct packed {
        logic [ADDR_MSB-ADDR_LSB:0] addr;
        logic [CMD_MSB-CMD_LSB:0]   code;
    } ir_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HOLD    = 2'd2
    } ir_state_e;

endpackage

// File: rtl/ms_ticker.sv
// Free-running millisecond prescaler: one-cycle tick every CLK_HZ/1000 cycles.
// Cleared only by reset; no backpressure, the tick is a pure timebase.
module ms_ticker #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == PW'(DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_cmd_filter.sv
// Turns raw IR receiver frames into one key event per press, with optional timed auto-repeat.
// Latency: fresh press visible one cycle after the data_rdy rising edge; no backpressure (strobe only).
module ir_cmd_filter
    import ir_pkg::*;
#(
    parameter int         CLK_HZ       = 50_000_000,
    parameter bit         ADDR_FILTER  = 1'b1,
    parameter logic [4:0] ADDR_MATCH   = 5'd1,
    parameter int         RELEASE_MS   = 120,
    parameter int         AR_DELAY_MS  = 500,
    parameter int         AR_PERIOD_MS = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] data,
    input  logic               data_rdy,
    output logic [FRAME_W-1:0] cmd,
    output logic               cmd_valid,
    output logic               held,
    output logic               repeat_evt
);

    localparam int AR_MAX = (AR_DELAY_MS > AR_PERIOD_MS) ? AR_DELAY_MS : AR_PERIOD_MS;
    localparam int RW     = $clog2(RELEASE_MS + 1);
    localparam int AW     = $clog2(AR_MAX + 1);

    logic               tick;
    logic               rdy_q;
    ir_state_e          state_q, state_d;
    logic [RW-1:0]      rel_q, rel_d;
    logic [AW-1:0]      ar_q, ar_d;
    logic [FRAME_W-1:0] cmd_q, cmd_d;
    logic               vld_q, vld_d;
    logic               rep_q, rep_d;

    ir_frame_t frame_in;
    logic      addr_ok;
    logic      frame_acc;
    logic      rel_exp;
    logic      ar_due;

    ms_ticker #(.CLK_HZ(CLK_HZ)) u_ticker (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign frame_in  = ir_frame_t'(data);
    assign addr_ok   = !ADDR_FILTER || (frame_in.addr == ADDR_MATCH);
    assign frame_acc = data_rdy && !rdy_q && addr_ok;
    assign rel_exp   = (rel_q == RW'(RELEASE_MS));
    assign ar_due    = (state_q == ST_HOLD) ? (ar_q >= AW'(AR_PERIOD_MS))
                                            : ((AR_DELAY_MS != 0) && (ar_q >= AW'(AR_DELAY_MS)));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        vld_d   = 1'b0;
        rep_d   = 1'b0;
        rel_d   = (tick && rel_q != RW'(RELEASE_MS)) ? rel_q + 1'b1 : rel_q;
        ar_d    = (tick && ar_q != AW'(AR_MAX)) ? ar_q + 1'b1 : ar_q;

        case (state_q)
            ST_PRESSED, ST_HOLD: begin
                if (frame_acc && data != cmd_q) begin
                    // A new key wins over any repeat due this cycle and restarts both timers.
                    state_d = ST_PRESSED;
                    cmd_d   = data;
                    vld_d   = 1'b1;
                    rel_d   = '0;
                    ar_d    = '0;
                end else begin
                    if (frame_acc) begin
                        rel_d = '0;
                    end else if (rel_exp) begin
                        state_d = ST_IDLE;
                        rel_d   = '0;
                        ar_d    = '0;
                    end
                    if (ar_due && (frame_acc || !rel_exp)) begin
                        state_d = ST_HOLD;
                        vld_d   = 1'b1;
                        rep_d   = 1'b1;
                        ar_d    = '0;
                    end
                end
            end
            default: begin
                rel_d = '0;
                ar_d  = '0;
                if (frame_acc) begin
                    state_d = ST_PRESSED;
                    cmd_d   = data;
                    vld_d   = 1'b1;
                end
            end
        endcase
    end

    // rdy_q resets high so a level already present at reset exit is not taken as a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q   <= 1'b1;
            state_q <= ST_IDLE;
            rel_q   <= '0;
            ar_q    <= '0;
            cmd_q   <= '0;
            vld_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            rdy_q   <= data_rdy;
            state_q <= state_d;
            rel_q   <= rel_d;
            ar_q    <= ar_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            rep_q   <= rep_d;
        end
    end

    assign cmd        = cmd_q;
    assign cmd_valid  = vld_q;
    assign repeat_evt = rep_q;
    assign held       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ir_cmd_filter.sv
// Directed bench: 10 cycles per ms; events checked against a queue of expected {repeat, cmd}.
module tb_ir_cmd_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] data;
    logic        data_rdy;
    logic [11:0] cmd, cmd2;
    logic        cmd_valid, cmd_valid2;
    logic        held, held2;
    logic        repeat_evt, repeat_evt2;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          ev_count = 0;
    int          ev2_count = 0;
    logic [12:0] sb[$];
    int          rep_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ir_cmd_filter #(
        .CLK_HZ(10_000), .ADDR_FILTER(1'b1), .ADDR_MATCH(5'd1),
        .RELEASE_MS(12), .AR_DELAY_MS(50), .AR_PERIOD_MS(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .data_rdy(data_rdy),
        .cmd(cmd), .cmd_valid(cmd_valid), .held(held), .repeat_evt(repeat_evt)
    );

    ir_cmd_filter #(
        .CLK_HZ(10_000), .ADDR_FILTER(1'b0), .ADDR_MATCH(5'd1),
        .RELEASE_MS(12), .AR_DELAY_MS(50), .AR_PERIOD_MS(20)
    ) dut_nf (
        .clk(clk), .rst_n(rst_n), .data(data), .data_rdy(data_rdy),
        .cmd(cmd2), .cmd_valid(cmd_valid2), .held(held2), .repeat_evt(repeat_evt2)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            logic [12:0] e;
            ev_count++;
            if (repeat_evt === 1'b1) rep_cyc.push_back(cyc);
            check("evt_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("evt_cmd", cmd, e[11:0]);
                check("evt_rep", repeat_evt, e[12]);
            end
        end
        if (cmd_valid2 === 1'b1) ev2_count++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame edge seen at posedge B; returns cyc at B; leaves data_rdy low at B+1.
    task automatic send_frame(input logic [11:0] f, input bit chk, output int cb);
        @(posedge clk);
        #1 data = f;
        data_rdy = 1'b1;
        @(posedge clk);
        #1 cb = cyc;
        if (chk) begin
            check("fresh_vld", cmd_valid, 1);
            check("fresh_cmd", cmd, f);
            check("fresh_rep", repeat_evt, 0);
        end
        @(posedge clk);
        #1 data_rdy = 1'b0;
    endtask

    initial begin
        int cb, c0, c_sw, ev_snap, ev2_snap, off;

        // 1: reset with data_rdy already high
        rst_n = 1'b0; data_rdy = 1'b1; data = 12'h095;
        wait_cyc(5);
        check("rst_cmd", cmd, 0);
        check("rst_vld", cmd_valid, 0);
        check("rst_held", held, 0);
        check("rst_rep", repeat_evt, 0);
        rst_n = 1'b1;
        wait_cyc(20);
        check("rst_exit_no_evt", ev_count, 0);
        check("rst_exit_held", held, 0);
        data_rdy = 1'b0;
        wait_cyc(5);

        // 2: single frame, release after ~12 ms
        sb.push_back({1'b0, 12'h095});
        send_frame(12'h095, 1'b1, c0);
        check("single_held", held, 1);
        wait_cyc(104);
        check("single_held_105", held, 1);
        wait_cyc(25);
        check("single_rel_130", held, 0);
        check("single_cnt", ev_count, 1);

        // 3: repeat frames for 40 ms -> one event
        ev_snap = ev_count;
        sb.push_back({1'b0, 12'h095});
        for (int i = 0; i < 9; i++) begin
            if (i > 0) check("t3_held", held, 1);
            send_frame(12'h095, (i == 0), cb);
            if (i < 8) wait_cyc(43);
        end
        wait_cyc(104);
        check("t3_held_tail", held, 1);
        wait_cyc(25);
        check("t3_rel", held, 0);
        check("t3_cnt", ev_count - ev_snap, 1);

        // 4: frames for ~100 ms -> fresh + repeats at ~50/70/90 ms
        rep_cyc.delete();
        sb.push_back({1'b0, 12'h095});
        for (int i = 0; i < 3; i++) sb.push_back({1'b1, 12'h095});
        for (int i = 0; i < 22; i++) begin
            send_frame(12'h095, (i == 0), cb);
            if (i == 0) c0 = cb;
            if (i < 21) wait_cyc(43);
        end
        wait_cyc(104);
        check("t4_held_tail", held, 1);
        wait_cyc(25);
        check("t4_rel", held, 0);
        check("t4_rep_count", rep_cyc.size(), 3);
        check("t4_sb_empty", sb.size(), 0);
        for (int i = 0; i < 3 && i < rep_cyc.size(); i++) begin
            off = rep_cyc[i] - c0;
            check("t4_rep_window", (off >= 485 + 200 * i) && (off <= 515 + 200 * i), 1);
        end

        // 5: foreign address, filtered vs unfiltered instance
        ev_snap = ev_count;
        ev2_snap = ev2_count;
        send_frame(12'h115, 1'b0, cb);
        check("t5_filt_cnt", ev_count - ev_snap, 0);
        check("t5_filt_held", held, 0);
        check("t5_nf_cnt", ev2_count - ev2_snap, 1);
        check("t5_nf_cmd", cmd2, 12'h115);
        check("t5_nf_rep", repeat_evt2, 0);
        check("t5_nf_held", held2, 1);
        wait_cyc(130);
        check("t5_nf_rel", held2, 0);

        // 6: switch code mid-hold, then reset mid-hold
        rep_cyc.delete();
        sb.push_back({1'b0, 12'h095});
        sb.push_back({1'b1, 12'h095});
        for (int i = 0; i < 13; i++) begin
            send_frame(12'h095, (i == 0), cb);
            wait_cyc(43);
        end
        check("t6_first_rep", rep_cyc.size(), 1);
        rep_cyc.delete();
        sb.push_back({1'b0, 12'h096});
        sb.push_back({1'b1, 12'h096});
        send_frame(12'h096, 1'b1, c_sw);
        for (int i = 1; i < 14; i++) begin
            wait_cyc(43);
            send_frame(12'h096, 1'b0, cb);
        end
        check("t6_held", held, 1);
        check("t6_rep_count", rep_cyc.size(), 1);
        if (rep_cyc.size() > 0) begin
            off = rep_cyc[0] - c_sw;
            check("t6_rep_restart", (off >= 485) && (off <= 515), 1);
        end
        ev_snap = ev_count;
        rst_n = 1'b0;
        wait_cyc(3);
        check("t6_rst_held", held, 0);
        check("t6_rst_cmd", cmd, 0);
        rst_n = 1'b1;
        wait_cyc(150);
        check("t6_post_held", held, 0);
        check("t6_post_cnt", ev_count - ev_snap, 0);
        check("t6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
